// File: rtl/wb_master.sv
// Single-outstanding Wishbone pipelined initiator bridging a load/store request port to the bus.
// Optional bus-cycle timeout is enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_master #(
    parameter int XLEN           = 32,
    parameter int XLEN_GRAN      = $clog2(XLEN / 8),
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [XLEN-1:0]           req_addr_i,
    input  logic                      req_we_i,
    input  logic [1:0]                req_size_i,
    input  logic                      req_signed_i,
    input  logic [XLEN-1:0]           req_wdata_i,
    output logic                      resp_valid_o,
    output logic                      resp_err_o,
    output logic [XLEN-1:0]           resp_rdata_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [XLEN-1:XLEN_GRAN]   addr_o,
    output logic [XLEN/8-1:0]         sel_o,
    output logic [XLEN-1:0]           dat_o,
    input  logic [XLEN-1:0]           dat_i,
    input  logic                      ack_i,
    input  logic                      err_i,
    input  logic                      stall_i
);

    localparam int SELW = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;

    logic                     r_cyc;
    logic                     r_stb;
    logic                     r_we;
    logic [XLEN-1:XLEN_GRAN]  r_addr;
    logic [SELW-1:0]          r_sel;
    logic [XLEN-1:0]          r_dat;
    logic [XLEN_GRAN-1:0]     r_off;
    logic [1:0]               r_size;
    logic                     r_signed;
    logic                     r_resp_err;
    logic [XLEN-1:0]          r_resp_rdata;

    logic [XLEN_GRAN-1:0]     w_req_off;
    logic [SELW-1:0]          w_req_mask;
    logic                     w_misaligned;
    logic                     w_accept;
    logic                     w_done;
    logic                     w_timeout;
    logic [XLEN-1:0]          w_shifted;
    logic [XLEN-1:0]          w_ext_mask;
    logic                     w_sign;
    logic [XLEN-1:0]          w_load;
    logic                     w_resp_err_next;
    logic [XLEN-1:0]          w_resp_rdata_next;

    assign w_req_off = req_addr_i[XLEN_GRAN-1:0];

    always_comb begin
        case (req_size_i)
            2'd0:    w_req_mask = SELW'(4'h1);
            2'd1:    w_req_mask = SELW'(4'h3);
            default: w_req_mask = SELW'(4'hF);
        endcase
    end

    assign w_misaligned = (req_size_i == 2'd3)
                       || (req_size_i == 2'd1 && req_addr_i[0])
                       || (req_size_i == 2'd2 && w_req_off != '0);

    assign w_accept = req_valid_i && (r_state == IDLE);

    // A strobe that is still stalled has not been taken, so any ack/err seen then is ignored.
    assign w_done = ((r_state == REQ) && !stall_i && (ack_i || err_i))
                 || ((r_state == WAIT) && (ack_i || err_i));

    assign w_shifted = dat_i >> {r_off, 3'b000};

    always_comb begin
        case (r_size)
            2'd0: begin
                w_ext_mask = XLEN'(8'hFF);
                w_sign     = w_shifted[7];
            end
            2'd1: begin
                w_ext_mask = XLEN'(16'hFFFF);
                w_sign     = w_shifted[15];
            end
            default: begin
                w_ext_mask = XLEN'(32'hFFFF_FFFF);
                w_sign     = w_shifted[31];
            end
        endcase
    end

    assign w_load = (w_shifted & w_ext_mask) | ((r_signed && w_sign) ? ~w_ext_mask : '0);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tmo_cnt <= '0;
        end else if (w_accept) begin
            r_tmo_cnt <= '0;
        end else if (r_state == REQ || r_state == WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Fires on the cycle whose increment brings the count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == REQ || r_state == WAIT)
                    && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
    // Counter compiled out: never times out for any legal TIMEOUT_CYCLES.
    assign w_timeout = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        w_state_next      = r_state;
        w_resp_err_next   = 1'b0;
        w_resp_rdata_next = '0;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    if (w_misaligned) begin
                        w_state_next    = RESP;
                        w_resp_err_next = 1'b1;
                    end else begin
                        w_state_next = REQ;
                    end
                end
            end
            REQ, WAIT: begin
                if (w_done) begin
                    w_state_next      = RESP;
                    w_resp_err_next   = err_i;
                    w_resp_rdata_next = (!err_i && !r_we) ? w_load : '0;
                end else if (w_timeout) begin
                    w_state_next    = RESP;
                    w_resp_err_next = 1'b1;
                end else if (r_state == REQ && !stall_i) begin
                    w_state_next = WAIT;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_sel        <= '0;
            r_dat        <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cyc        <= (w_state_next == REQ) || (w_state_next == WAIT);
            r_stb        <= (w_state_next == REQ);
            r_resp_err   <= w_resp_err_next;
            r_resp_rdata <= w_resp_rdata_next;
            if (w_accept) begin
                r_off    <= w_req_off;
                r_size   <= req_size_i;
                r_signed <= req_signed_i;
                if (!w_misaligned) begin
                    r_we   <= req_we_i;
                    r_addr <= req_addr_i[XLEN-1:XLEN_GRAN];
                    r_sel  <= w_req_mask << w_req_off;
                    r_dat  <= req_wdata_i << {w_req_off, 3'b000};
                end
            end
        end
    end

    assign req_ready_o  = (r_state == IDLE);
    assign resp_valid_o = (r_state == RESP);
    assign resp_err_o   = r_resp_err;
    assign resp_rdata_o = r_resp_rdata;
    assign cyc_o        = r_cyc;
    assign stb_o        = r_stb;
    assign we_o         = r_we;
    assign addr_o       = r_addr;
    assign sel_o        = r_sel;
    assign dat_o        = r_dat;

endmodule

// File: tb/tb_wb_master.sv
// Self-checking bench for wb_master: scripted Wishbone slave plus a response scoreboard.
module tb_wb_master;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [31:0] req_addr_i = '0;
    logic        req_we_i = 1'b0;
    logic [1:0]  req_size_i = '0;
    logic        req_signed_i = 1'b0;
    logic [31:0] req_wdata_i = '0;
    logic        resp_valid_o;
    logic        resp_err_o;
    logic [31:0] resp_rdata_o;
    logic        cyc_o;
    logic        stb_o;
    logic        we_o;
    logic [31:2] addr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i = '0;
    logic        ack_i = 1'b0;
    logic        err_i = 1'b0;
    logic        stall_i = 1'b0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc_cnt = 0;

    wb_master #(
        .XLEN           (32),
        .XLEN_GRAN      (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .req_wdata_i  (req_wdata_i),
        .resp_valid_o (resp_valid_o),
        .resp_err_o   (resp_err_o),
        .resp_rdata_o (resp_rdata_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .addr_o       (addr_o),
        .sel_o        (sel_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .stall_i      (stall_i)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    // Slave modes: 0 ack in WAIT, 1 ack+err in WAIT, 2 ack with the strobe,
    // 3 never respond, 4 misaligned (no bus cycle expected).
    // Called just after a falling edge; returns just after a falling edge with the DUT idle.
    task automatic txn(input logic [31:0] addr, input logic we, input logic [1:0] size,
                       input logic sgn, input logic [31:0] wdata, input logic [31:0] rdat,
                       input int nstall, input int mode, input logic [29:0] e_addr,
                       input logic [3:0] e_sel, input logic [31:0] e_dat, input logic e_err,
                       input logic [31:0] e_rdata, input int e_lat, output int acc);
        exp_t e;
        int   t0;
        int   stall_left;
        bit   seen;
        bit   saw_cyc;
        sb_q.push_back('{e_err, e_rdata, e_lat});
        tests++;
        if (req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_accept: got %b expected 1", req_ready_o);
        end
        req_valid_i  = 1'b1;
        req_addr_i   = addr;
        req_we_i     = we;
        req_size_i   = size;
        req_signed_i = sgn;
        req_wdata_i  = wdata;
        dat_i        = rdat;
        @(posedge clk_i);
        #1;
        t0          = cyc_cnt;
        acc         = t0;
        req_valid_i = 1'b0;
        stall_left  = nstall;
        seen        = 1'b0;
        saw_cyc     = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk_i);
            stall_i = 1'b0;
            ack_i   = 1'b0;
            err_i   = 1'b0;
            if (cyc_o === 1'b1) saw_cyc = 1'b1;
            if (resp_valid_o === 1'b1) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                tests++;
                if (resp_err_o !== e.err) begin
                    fails++;
                    $display("FAIL resp_err @%08h: got %b expected %b", addr, resp_err_o, e.err);
                end
                tests++;
                if (resp_rdata_o !== e.rdata) begin
                    fails++;
                    $display("FAIL resp_rdata @%08h: got %08h expected %08h", addr, resp_rdata_o, e.rdata);
                end
                tests++;
                if (cyc_cnt - t0 + 1 != e.lat) begin
                    fails++;
                    $display("FAIL latency @%08h: got %0d expected %0d", addr, cyc_cnt - t0 + 1, e.lat);
                end
                tests++;
                if (saw_cyc !== (mode != 4)) begin
                    fails++;
                    $display("FAIL cyc_seen @%08h: got %b expected %b", addr, saw_cyc, (mode != 4));
                end
                if (mode == 3) ack_i = 1'b1;
            end else if (stb_o === 1'b1) begin
                tests++;
                if ({we_o, addr_o, sel_o, dat_o} !== {we, e_addr, e_sel, e_dat}) begin
                    fails++;
                    $display("FAIL bus @%08h: got we=%b addr=%08h sel=%h dat=%08h expected we=%b addr=%08h sel=%h dat=%08h",
                             addr, we_o, addr_o, sel_o, dat_o, we, e_addr, e_sel, e_dat);
                end
                if (stall_left > 0) begin
                    stall_i = 1'b1;
                    stall_left--;
                end else if (mode == 2) begin
                    ack_i = 1'b1;
                end
            end else if (cyc_o === 1'b1) begin
                if (mode == 0) begin
                    ack_i = 1'b1;
                end else if (mode == 1) begin
                    ack_i = 1'b1;
                    err_i = 1'b1;
                end
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL resp_wait @%08h: got no resp_valid_o expected one within 40 cycles", addr);
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        @(negedge clk_i);
        stall_i = 1'b0;
        ack_i   = 1'b0;
        err_i   = 1'b0;
        tests++;
        if ({resp_valid_o, req_ready_o, cyc_o} !== 3'b010) begin
            fails++;
            $display("FAIL after_resp @%08h: got valid=%b ready=%b cyc=%b expected 0 1 0",
                     addr, resp_valid_o, req_ready_o, cyc_o);
        end
        $display("[TB] txn addr=%08h we=%b size=%0d mode=%0d resp_err=%b rdata=%08h",
                 addr, we, size, mode, e_err, e_rdata);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        tests++;
        if (req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready: got %b expected 1", req_ready_o);
        end
        tests++;
        if ({cyc_o, stb_o, we_o, resp_valid_o, resp_err_o} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ctrl: got %b expected 00000",
                     {cyc_o, stb_o, we_o, resp_valid_o, resp_err_o});
        end
        tests++;
        if ({addr_o, sel_o, dat_o, resp_rdata_o} !== '0) begin
            fails++;
            $display("FAIL reset_data: got addr=%08h sel=%h dat=%08h rdata=%08h expected all 0",
                     addr_o, sel_o, dat_o, resp_rdata_o);
        end
        rst_i = 1'b0;
        @(negedge clk_i);
        $display("[TB] reset checked");
    endtask

    task automatic test_stores();
        int a;
        txn(32'h10, 1'b1, 2'd2, 1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 0, 0,
            30'h4, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 3, a);
        txn(32'h22, 1'b1, 2'd1, 1'b0, 32'h00001234, 32'h0, 1, 0,
            30'h8, 4'hC, 32'h12340000, 1'b0, 32'h0, 4, a);
        txn(32'h31, 1'b1, 2'd0, 1'b0, 32'h000000A5, 32'h0, 0, 0,
            30'hC, 4'h2, 32'h0000A500, 1'b0, 32'h0, 3, a);
    endtask

    task automatic test_loads();
        int a;
        txn(32'h13, 1'b0, 2'd0, 1'b1, 32'h0, 32'h80112233, 2, 0,
            30'h4, 4'h8, 32'h0, 1'b0, 32'hFFFFFF80, 5, a);
        txn(32'h13, 1'b0, 2'd0, 1'b0, 32'h0, 32'h80112233, 0, 0,
            30'h4, 4'h8, 32'h0, 1'b0, 32'h00000080, 3, a);
        txn(32'h22, 1'b0, 2'd1, 1'b1, 32'h0, 32'hF00D1234, 0, 0,
            30'h8, 4'hC, 32'h0, 1'b0, 32'hFFFFF00D, 3, a);
        txn(32'h20, 1'b0, 2'd1, 1'b0, 32'h0, 32'h00AA8001, 0, 0,
            30'h8, 4'h3, 32'h0, 1'b0, 32'h00008001, 3, a);
        txn(32'h24, 1'b0, 2'd2, 1'b1, 32'h0, 32'h12345678, 1, 2,
            30'h9, 4'hF, 32'h0, 1'b0, 32'h12345678, 3, a);
    endtask

    task automatic test_misaligned();
        int a;
        txn(32'h21, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 0, 4,
            30'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1, a);
        txn(32'h12, 1'b1, 2'd2, 1'b0, 32'h55555555, 32'h0, 0, 4,
            30'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1, a);
        txn(32'h40, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 0, 4,
            30'h0, 4'h0, 32'h0, 1'b1, 32'h0, 1, a);
    endtask

    task automatic test_ack_err();
        int a;
        txn(32'h00, 1'b0, 2'd2, 1'b0, 32'h0, 32'hCAFEF00D, 0, 1,
            30'h0, 4'hF, 32'h0, 1'b1, 32'h0, 3, a);
    endtask

    task automatic test_back_to_back();
        int a0;
        int a1;
        txn(32'h44, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0BADCAFE, 0, 0,
            30'h11, 4'hF, 32'h0, 1'b0, 32'h0BADCAFE, 3, a0);
        txn(32'h48, 1'b1, 2'd2, 1'b0, 32'h600DF00D, 32'h0, 0, 0,
            30'h12, 4'hF, 32'h600DF00D, 1'b0, 32'h0, 3, a1);
        tests++;
        if (a1 - a0 != 4) begin
            fails++;
            $display("FAIL back_to_back_spacing: got %0d expected 4", a1 - a0);
        end
    endtask

`ifdef WB_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int a;
        txn(32'h50, 1'b0, 2'd2, 1'b0, 32'h0, 32'h11111111, 0, 3,
            30'h14, 4'hF, 32'h0, 1'b1, 32'h0, 9, a);
    endtask
`endif

    task automatic test_reset_in_wait();
        req_valid_i  = 1'b1;
        req_addr_i   = 32'h60;
        req_we_i     = 1'b0;
        req_size_i   = 2'd2;
        req_signed_i = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        tests++;
        if ({cyc_o, stb_o} !== 2'b10) begin
            fails++;
            $display("FAIL wait_state: got cyc=%b stb=%b expected 1 0", cyc_o, stb_o);
        end
        #2;
        rst_i = 1'b1;
        #1;
        tests++;
        if ({cyc_o, stb_o} !== 2'b00) begin
            fails++;
            $display("FAIL async_reset_drop: got cyc=%b stb=%b expected 0 0", cyc_o, stb_o);
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        ack_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            ack_i = 1'b0;
            tests++;
            if ({resp_valid_o, req_ready_o, cyc_o} !== 3'b010) begin
                fails++;
                $display("FAIL post_reset: got valid=%b ready=%b cyc=%b expected 0 1 0",
                         resp_valid_o, req_ready_o, cyc_o);
            end
        end
        $display("[TB] reset during WAIT checked");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stores();
        test_loads();
        test_misaligned();
        test_ack_err();
        test_back_to_back();
`ifdef WB_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
